// File: rtl/kws_pkg.sv
`default_nettype none
// ============================================================================
// kws_pkg : shared constants, FSM encoding and width helper for the KWS block
// Revision: 1.0
// ============================================================================
package kws_pkg;

    localparam int SEQ_W    = 16;
    localparam int STREAK_W = 4;
    localparam int HOLD_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HOLDOFF = 2'd2
    } kws_state_e;

    // Index width for an n-bit one-hot vector; never narrower than one bit.
    function automatic int kw_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kws_evt_fifo.sv
`default_nettype none
// ============================================================================
// kws_evt_fifo : synchronous FIFO for detected keyword events, head shown on rdata
// Revision: 1.0
// ============================================================================
module kws_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]  wr_ptr_q;
    logic [ADDR_W:0]  rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/kws_event_detector.sv
`default_nettype none
// ============================================================================
// kws_event_detector : debounces one-hot keyword results into queued events
// Revision: 1.0
// ============================================================================
module kws_event_detector
    import kws_pkg::*;
#(
    parameter int NUM_KEYWORDS   = 10,
    parameter int CONFIRM_COUNT  = 3,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int FIFO_DEPTH     = 4,
    localparam int KW_IDX_W      = kw_idx_width(NUM_KEYWORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_KEYWORDS-1:0] kws_result,
    input  logic                    kws_valid,
    input  logic                    enable,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [KW_IDX_W-1:0]     evt_keyword,
    output logic [SEQ_W-1:0]        evt_seq,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic                    busy
);

    localparam int EVT_W = KW_IDX_W + SEQ_W;
    localparam logic [NUM_KEYWORDS-1:0] C_KW_ONE     = NUM_KEYWORDS'(1);
    localparam logic [STREAK_W-1:0]     C_CONFIRM    = STREAK_W'(CONFIRM_COUNT);
    localparam logic [STREAK_W-1:0]     C_STREAK_ONE = STREAK_W'(1);
    localparam logic [HOLD_W-1:0]       C_HOLD_LOAD  = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [HOLD_W-1:0]       C_HOLD_ONE   = HOLD_W'(1);
    localparam logic [SEQ_W-1:0]        C_SEQ_ONE    = SEQ_W'(1);

    function automatic logic [KW_IDX_W-1:0] onehot_to_idx(input logic [NUM_KEYWORDS-1:0] v);
        logic [KW_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYWORDS; i++) begin
            if (v[i]) idx = idx | KW_IDX_W'(i);
        end
        return idx;
    endfunction

    kws_state_e          state_q, state_d;
    logic [KW_IDX_W-1:0] cand_q, cand_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                overflow_q, overflow_d;

    logic                w_onehot, w_hit, w_miss, w_push;
    logic                w_full, w_empty, w_pop_ok, w_drop;
    logic [KW_IDX_W-1:0] w_hit_idx;
    logic [SEQ_W-1:0]    w_seq_inc;
    logic [EVT_W-1:0]    w_evt_data, w_head;

    assign w_onehot   = (kws_result != '0) && ((kws_result & (kws_result - C_KW_ONE)) == '0);
    assign w_hit      = enable & kws_valid & w_onehot;
    assign w_miss     = enable & kws_valid & ~w_onehot;
    assign w_hit_idx  = onehot_to_idx(kws_result);
    // The pushed sequence number already includes the confirming result.
    assign w_seq_inc  = seq_q + C_SEQ_ONE;
    assign seq_d      = (enable && kws_valid) ? w_seq_inc : seq_q;
    assign w_evt_data = {w_hit_idx, w_seq_inc};

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        hold_d   = hold_q;
        w_push   = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            streak_d = '0;
            hold_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_hit) begin
                        cand_d   = w_hit_idx;
                        streak_d = C_STREAK_ONE;
                        if (C_CONFIRM == C_STREAK_ONE) begin
                            w_push   = 1'b1;
                            streak_d = '0;
                            hold_d   = C_HOLD_LOAD;
                            state_d  = ST_HOLDOFF;
                        end else begin
                            state_d  = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (w_hit) begin
                        if (w_hit_idx == cand_q) begin
                            if ((streak_q + C_STREAK_ONE) == C_CONFIRM) begin
                                w_push   = 1'b1;
                                streak_d = '0;
                                hold_d   = C_HOLD_LOAD;
                                state_d  = ST_HOLDOFF;
                            end else begin
                                streak_d = streak_q + C_STREAK_ONE;
                            end
                        end else begin
                            cand_d   = w_hit_idx;
                            streak_d = C_STREAK_ONE;
                        end
                    end else if (w_miss) begin
                        streak_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_q == '0) state_d = ST_IDLE;
                    else              hold_d  = hold_q - C_HOLD_ONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign w_pop_ok   = evt_ready & ~w_empty;
    assign w_drop     = w_push & w_full & ~w_pop_ok;
    assign overflow_d = w_drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            streak_q   <= '0;
            hold_q     <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            streak_q   <= streak_d;
            hold_q     <= hold_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    kws_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .wdata_i (w_evt_data),
        .pop_i   (evt_ready),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign evt_valid   = ~w_empty;
    assign evt_keyword = w_head[EVT_W-1:SEQ_W];
    assign evt_seq     = w_head[SEQ_W-1:0];
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kws_event_detector.sv
`default_nettype none
// ============================================================================
// tb_kws_event_detector : directed scenarios plus random traffic vs. event model
// Revision: 1.0
// ============================================================================
module tb_kws_event_detector;

    localparam int NK = 10;
    localparam int CC = 3;
    localparam int HC = 16;
    localparam int FD = 4;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b1;
    logic [NK-1:0] kws_result     = '0;
    logic          kws_valid      = 1'b0;
    logic          enable         = 1'b0;
    logic          evt_ready      = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          evt_valid;
    logic [3:0]    evt_keyword;
    logic [15:0]   evt_seq;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    kws_event_detector #(
        .NUM_KEYWORDS   (NK),
        .CONFIRM_COUNT  (CC),
        .HOLDOFF_CYCLES (HC),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .kws_result     (kws_result),
        .kws_valid      (kws_valid),
        .enable         (enable),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_keyword    (evt_keyword),
        .evt_seq        (evt_seq),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .busy           (busy)
    );

    typedef struct {
        int kw;
        int seq;
    } evt_t;

    // Event-level model: run length of identical hits, absolute holdoff end time.
    evt_t m_q[$];
    int   m_seq, m_cand, m_run, m_cyc, m_hold_end;
    bit   m_holding, m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_seq     = 0;
        m_cand    = 0;
        m_run     = 0;
        m_cyc     = 0;
        m_hold_end = 0;
        m_holding = 1'b0;
        m_ovf     = 1'b0;
    endfunction

    function automatic void model_step();
        bit   pop, push, drop;
        int   idx;
        evt_t e;
        m_cyc++;
        pop  = evt_ready && (m_q.size() > 0);
        push = 1'b0;
        drop = 1'b0;
        e.kw = 0;
        e.seq = 0;
        if (!enable) begin
            m_run     = 0;
            m_holding = 1'b0;
        end else begin
            if (kws_valid) m_seq = (m_seq + 1) & 16'hFFFF;
            if (m_holding) begin
                m_holding = (m_cyc < m_hold_end);
            end else if (kws_valid) begin
                if ($countones(kws_result) == 1) begin
                    idx = $clog2(kws_result);
                    if (m_run > 0 && idx == m_cand) m_run++;
                    else begin
                        m_cand = idx;
                        m_run  = 1;
                    end
                    if (m_run == CC) begin
                        push       = 1'b1;
                        e.kw       = idx;
                        e.seq      = m_seq;
                        m_run      = 0;
                        m_holding  = 1'b1;
                        m_hold_end = m_cyc + HC;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(e);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
    endfunction

    task automatic check_outputs();
        check("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("evt_keyword", 32'(evt_keyword), 32'(m_q[0].kw));
            check("evt_seq", 32'(evt_seq), 32'(m_q[0].seq));
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_holding || m_run > 0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [NK-1:0] r);
        kws_valid  = v;
        kws_result = r;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    task automatic hits3(input int kw);
        logic [NK-1:0] oh;
        oh = NK'(1) << kw;
        drive(1'b1, oh);
        drive(1'b0, '0);
        drive(1'b1, oh);
        drive(1'b0, '0);
        drive(1'b1, oh);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_keyword", 32'(evt_keyword), 32'd0);
        check("rst_evt_seq", 32'(evt_seq), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        kws_valid      = 1'b0;
        kws_result     = '0;
        enable         = 1'b1;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cur_key, a, b;
        #2;
        do_reset();

        // Three spaced hits produce one event visible right after the third.
        evt_ready = 1'b1;
        hits3(2);
        check("s1_valid", 32'(evt_valid), 32'd1);
        check("s1_kw", 32'(evt_keyword), 32'd2);
        check("s1_seq", 32'(evt_seq), 32'd3);
        idle(HC + 2);

        do_reset();
        evt_ready = 1'b1;
        drive(1'b1, 10'h004);
        drive(1'b1, 10'h004);
        drive(1'b1, 10'h010);
        drive(1'b1, 10'h010);
        drive(1'b1, 10'h010);
        check("s2_valid", 32'(evt_valid), 32'd1);
        check("s2_kw", 32'(evt_keyword), 32'd4);
        check("s2_seq", 32'(evt_seq), 32'd5);
        idle(HC + 2);

        do_reset();
        evt_ready = 1'b1;
        drive(1'b1, 10'h004);
        drive(1'b1, 10'h006);
        drive(1'b1, 10'h004);
        drive(1'b1, 10'h004);
        check("s3_busy", 32'(busy), 32'd1);
        check("s3_valid", 32'(evt_valid), 32'd0);
        idle(4);
        enable = 1'b0;
        idle(1);
        check("s3_disable_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        do_reset();
        evt_ready = 1'b1;
        hits3(1);
        drive(1'b1, 10'h008);
        drive(1'b1, 10'h008);
        drive(1'b1, 10'h008);
        check("s4_holdoff_valid", 32'(evt_valid), 32'd0);
        idle(HC);
        drive(1'b1, 10'h008);
        drive(1'b1, 10'h008);
        drive(1'b1, 10'h008);
        check("s4_valid", 32'(evt_valid), 32'd1);
        check("s4_kw", 32'(evt_keyword), 32'd3);
        idle(HC + 2);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            hits3(k);
            idle(HC + 1);
        end
        check("s5_overflow", 32'(overflow), 32'd1);
        check("s5_depth", 32'(m_q.size()), 32'(FD));
        evt_ready = 1'b1;
        for (int i = 0; i < FD; i++) begin
            check("s5_drain_kw", 32'(evt_keyword), 32'(i));
            tick();
        end
        check("s5_empty", 32'(evt_valid), 32'd0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("s5_cleared", 32'(overflow), 32'd0);

        do_reset();
        hits3(0);
        idle(HC + 1);
        hits3(1);
        idle(3);
        check("s6_queued", 32'(m_q.size()), 32'd2);
        do_reset();
        evt_ready = 1'b1;
        hits3(5);
        check("s6_seq", 32'(evt_seq), 32'(CC));
        idle(HC + 2);

        do_reset();
        cur_key = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(9) == 0) cur_key = $urandom_range(NK - 1);
            enable         = ($urandom_range(99) >= 3);
            kws_valid      = ($urandom_range(99) < 70);
            clear_overflow = ($urandom_range(99) < 2);
            evt_ready      = ((i % 400) < 150) ? 1'b0 : ($urandom_range(1) == 1);
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: kws_result = NK'(1) << cur_key;
                6:       kws_result = NK'(1) << $urandom_range(NK - 1);
                7:       kws_result = '0;
                8: begin
                    a = $urandom_range(NK - 1);
                    b = (a + 1 + $urandom_range(NK - 2)) % NK;
                    kws_result = (NK'(1) << a) | (NK'(1) << b);
                end
                default: kws_result = NK'($urandom);
            endcase
            tick();
            if ((i % 1000) == 999) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
